cp0_int_resp: RTL

- Coprocessor-0 interrupt and exception responder inside the pipelined MIPS CPU, sitting at the M stage.
- Samples the external `interrupt` line (driven by the bench or device bridge) and synchronous exception reports from the pipeline.
- Decides when to divert to the handler, captures EPC/Cause/BD, and exposes the SR/Cause/EPC/PRId registers to mfc0/mtc0/eret.
- Also drives the macroscopic PC output `addr` that the bench monitors.

---
 rtl/cp0_pkg.sv | 33 +++
 rtl/cp0_ip_sampler.sv | 42 ++++
 rtl/cp0_int_resp.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes and vectors.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LSB   = 10;
    localparam int IM_MSB   = 15;
    localparam int IP_LSB   = 10;
    localparam int IP_MSB   = 15;
    localparam int EXC_LSB  = 2;
    localparam int EXC_MSB  = 6;
    localparam int CAUSE_BD = 31;
    localparam int NIP      = IP_MSB - IP_LSB + 1;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_DEF       = 32'h2020_0007;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_ip_sampler.sv
// Cause.IP register. Default: level-sampled each cycle. With CP0_INT_LATCH_EN,
// bits become sticky on a rising edge of hw_int and clear via clr_i.
module cp0_ip_sampler #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] hw_int_i,
`ifdef CP0_INT_LATCH_EN
    input  logic [W-1:0] clr_i,
`endif
    output logic [W-1:0] ip_o
);

    logic [W-1:0] ip_q;

`ifdef CP0_INT_LATCH_EN
    logic [W-1:0] hw_q;
    logic [W-1:0] ip_d;

    // A new rising edge wins over a same-cycle clear so the event is not lost.
    always_comb ip_d = (ip_q & ~clr_i) | (hw_int_i & ~hw_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_q <= '0;
            hw_q <= '0;
        end else begin
            ip_q <= ip_d;
            hw_q <= hw_int_i;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ip_q <= '0;
        else        ip_q <= hw_int_i;
    end
`endif

    assign ip_o = ip_q;

endmodule

// File: rtl/cp0_int_resp.sv
// CP0 interrupt/exception responder at the M stage: SR/Cause/EPC/PRId, entry and eret.
// Optional sticky interrupt pending bits: define CP0_INT_LATCH_EN.
module cp0_int_resp
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_DEF,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [31:0]         pc_m,
    input  logic                pc_m_valid,
    input  logic                bd_m,
    input  logic                exc_m,
    input  logic [4:0]          exc_code_m,
    input  logic                eret_m,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    output logic                take_exc,
    output logic [31:0]         next_pc,
    output logic [31:0]         epc,
    output logic [31:0]         addr
);

    logic           ie_q, ie_d, exl_q, exl_d, bd_q, bd_d, run_q;
    logic [NIP-1:0] im_q, im_d;
    logic [4:0]     code_q, code_d;
    logic [31:0]    epc_q, epc_d, addr_q, addr_d;
    logic [HW_INT_W-1:0] ip;
    logic [NIP-1:0] ip_ext;
    logic           int_req, take;

    always_comb begin
        ip_ext = '0;
        ip_ext[HW_INT_W-1:0] = ip;
    end

    assign int_req = ie_q & ~exl_q & (|(im_q & ip_ext));
    // run_q keeps the responder idle until the first edge after reset release.
    assign take    = run_q & pc_m_valid & ~exl_q & (int_req | exc_m);

`ifdef CP0_INT_LATCH_EN
    logic [NIP-1:0]      clr_ext;
    logic [HW_INT_W-1:0] clr;

    always_comb begin
        clr_ext = '0;
        if (take && int_req)
            clr_ext = im_q;
        else if (!take && !eret_m && cp0_we && cp0_addr == CP0_CAUSE)
            clr_ext = ~cp0_wdata[IP_MSB:IP_LSB];
        clr = clr_ext[HW_INT_W-1:0];
    end
`endif

    cp0_ip_sampler #(.W(HW_INT_W)) u_ip (
        .clk      (clk),
        .reset    (reset),
        .hw_int_i (hw_int),
`ifdef CP0_INT_LATCH_EN
        .clr_i    (clr),
`endif
        .ip_o     (ip)
    );

    // Entry beats eret beats mtc0; a taken instruction commits nothing.
    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        im_d   = im_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        addr_d = pc_m_valid ? pc_m : addr_q;
        if (take) begin
            exl_d  = 1'b1;
            code_d = int_req ? EXC_INT : exc_code_m;
            bd_d   = bd_m;
            epc_d  = word_align(bd_m ? pc_m - 32'd4 : pc_m);
        end else if (eret_m) begin
            exl_d = 1'b0;
        end else if (cp0_we) begin
            case (cp0_addr)
                CP0_SR: begin
                    im_d  = cp0_wdata[IM_MSB:IM_LSB];
                    exl_d = cp0_wdata[SR_EXL];
                    ie_d  = cp0_wdata[SR_IE];
                end
                CP0_EPC: epc_d = word_align(cp0_wdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            im_q   <= '0;
            bd_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
            addr_q <= '0;
            run_q  <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            im_q   <= im_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            addr_q <= addr_d;
            run_q  <= 1'b1;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR: begin
                cp0_rdata[IM_MSB:IM_LSB] = im_q;
                cp0_rdata[SR_EXL]        = exl_q;
                cp0_rdata[SR_IE]         = ie_q;
            end
            CP0_CAUSE: begin
                cp0_rdata[CAUSE_BD]        = bd_q;
                cp0_rdata[IP_MSB:IP_LSB]   = ip_ext;
                cp0_rdata[EXC_MSB:EXC_LSB] = code_q;
            end
            CP0_EPC:  cp0_rdata = epc_q;
            CP0_PRID: cp0_rdata = PRID_VAL;
            default:  ;
        endcase
    end

    assign take_exc = take;
    assign next_pc  = take ? HANDLER_PC : epc_q;
    assign epc      = epc_q;
    assign addr     = (run_q && pc_m_valid) ? pc_m : addr_q;

endmodule
